cross_bar_arb: RTL and testbench

CROSS_BAR_ARB -- requirements
Module: cross_bar_arb

---
 rtl/cross_bar_arb.sv | 137 +++++++++++++
 tb/tb_cross_bar_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_arb.sv
// Round-robin arbiter granting NUM_M masters access to one shared slave port,
// with exactly one transaction in flight (IDLE -> REQ -> optional RESP).
module cross_bar_arb #(
    parameter int NUM_M  = 4,
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_M-1:0]           m_req,
    input  logic [NUM_M*AWIDTH-1:0]    m_addr,
    input  logic [NUM_M-1:0]           m_cmd,
    input  logic [NUM_M*DWIDTH-1:0]    m_wdata,
    output logic [NUM_M-1:0]           m_ack,
    output logic [NUM_M*DWIDTH-1:0]    m_rdata,
    output logic [NUM_M-1:0]           m_resp,
    output logic                       s_req,
    output logic [AWIDTH-1:0]          s_addr,
    output logic                       s_cmd,
    output logic [DWIDTH-1:0]          s_wdata,
    input  logic                       s_ack,
    input  logic                       s_resp,
    input  logic [DWIDTH-1:0]          s_rdata,
    output logic [$clog2(NUM_M)-1:0]   grant_id,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    // Handshake: a request is held (s_req high with stable addr/cmd/wdata) until
    // the slave pulses s_ack in the same cycle; a read then waits for one s_resp
    // pulse carrying s_rdata. m_ack/m_resp are single-cycle pulses to the winner.

    localparam int GW  = $clog2(NUM_M);
    localparam int GW1 = GW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [GW-1:0]     last_grant, last_nxt, grant_nxt, winner;
    logic [GW:0]       idx;
    logic              found;
    logic              sel_req, sel_cmd;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;

    // First requester searching upward from last_grant+1, wrapping at NUM_M.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = {1'b0, last_grant} + GW1'(k);
            if (idx >= GW1'(NUM_M)) idx = idx - GW1'(NUM_M);
            if (!found && m_req[idx[GW-1:0]]) begin
                winner = idx[GW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_req   = 1'b0;
        sel_cmd   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_id == GW'(i)) begin
                sel_req   = m_req[i];
                sel_cmd   = m_cmd[i];
                sel_addr  = m_addr[i*AWIDTH +: AWIDTH];
                sel_wdata = m_wdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign s_req     = (state == ST_REQ) && sel_req;
    assign s_cmd     = (state == ST_REQ) && sel_cmd;
    assign s_addr    = (state == ST_REQ) ? sel_addr : '0;
    assign s_wdata   = (state == ST_REQ) ? sel_wdata : '0;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        m_ack   = '0;
        m_resp  = '0;
        m_rdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_id == GW'(i)) begin
                m_ack[i]  = (state == ST_REQ) && s_ack;
                m_resp[i] = (state == ST_RESP) && s_resp;
                if (state == ST_RESP) m_rdata[i*DWIDTH +: DWIDTH] = s_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        case (state)
            ST_IDLE: begin
                if (|m_req) begin
                    grant_nxt = winner;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (s_ack) begin
                    last_nxt  = grant_id;
                    state_nxt = sel_cmd ? ST_IDLE : ST_RESP;
                end else if (!sel_req) begin
                    // Withdrawn request: priority pointer stays where it was.
                    state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (s_resp) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_M - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

endmodule

// File: tb/tb_cross_bar_arb.sv
// Directed bench for cross_bar_arb: a transaction-level model checked every
// cycle, plus literal expectations for the single write/read, round-robin and reset cases.
module tb_cross_bar_arb;

    localparam int NUM_M = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int GW    = $clog2(NUM_M);

    logic                   aclk;
    logic                   aresetn;
    logic [NUM_M-1:0]       m_req;
    logic [NUM_M*AW-1:0]    m_addr;
    logic [NUM_M-1:0]       m_cmd;
    logic [NUM_M*DW-1:0]    m_wdata;
    logic [NUM_M-1:0]       m_ack;
    logic [NUM_M*DW-1:0]    m_rdata;
    logic [NUM_M-1:0]       m_resp;
    logic                   s_req;
    logic [AW-1:0]          s_addr;
    logic                   s_cmd;
    logic [DW-1:0]          s_wdata;
    logic                   s_ack;
    logic                   s_resp;
    logic [DW-1:0]          s_rdata;
    logic [GW-1:0]          grant_id;
    logic                   busy;
    logic [1:0]             dbg_state;

    int checks = 0;
    int errors = 0;

    cross_bar_arb #(.NUM_M(NUM_M), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_resp(m_resp),
        .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 = nothing granted, 1 = request outstanding, 2 = awaiting read data
    int mdl_phase = 0;
    int mdl_gid   = 0;
    int mdl_last  = NUM_M - 1;

    function automatic int pick(input logic [NUM_M-1:0] r, input int last);
        for (int k = 1; k <= NUM_M; k++) begin
            int c;
            c = (last + k) % NUM_M;
            if (r[c]) return c;
        end
        return last;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mdl_phase = 0;
            mdl_gid   = 0;
            mdl_last  = NUM_M - 1;
        end else begin
            case (mdl_phase)
                0: if (m_req != 0) begin
                    mdl_gid   = pick(m_req, mdl_last);
                    mdl_phase = 1;
                end
                1: if (s_ack) begin
                    mdl_last  = mdl_gid;
                    mdl_phase = m_cmd[mdl_gid] ? 0 : 2;
                end else if (!m_req[mdl_gid]) begin
                    mdl_phase = 0;
                end
                default: if (s_resp) mdl_phase = 0;
            endcase
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge aclk) begin
        logic [NUM_M-1:0]    e_ack, e_resp;
        logic [NUM_M*DW-1:0] e_rdata;
        logic                e_sreq, e_scmd;
        logic [AW-1:0]       e_saddr;
        logic [DW-1:0]       e_swdata;
        e_ack    = '0;
        e_resp   = '0;
        e_rdata  = '0;
        e_sreq   = 1'b0;
        e_scmd   = 1'b0;
        e_saddr  = '0;
        e_swdata = '0;
        if (mdl_phase == 1) begin
            e_sreq       = m_req[mdl_gid];
            e_scmd       = m_cmd[mdl_gid];
            e_saddr      = m_addr[mdl_gid*AW +: AW];
            e_swdata     = m_wdata[mdl_gid*DW +: DW];
            e_ack[mdl_gid] = s_ack;
        end
        if (mdl_phase == 2) begin
            e_resp[mdl_gid]             = s_resp;
            e_rdata[mdl_gid*DW +: DW]   = s_rdata;
        end
        check("mdl_busy",     busy,     mdl_phase != 0);
        check("mdl_grant_id", grant_id, mdl_gid);
        check("mdl_s_req",    s_req,    e_sreq);
        check("mdl_s_cmd",    s_cmd,    e_scmd);
        check("mdl_s_addr",   s_addr,   e_saddr);
        check("mdl_s_wdata",  s_wdata,  e_swdata);
        check("mdl_m_ack",    m_ack,    e_ack);
        check("mdl_m_resp",   m_resp,   e_resp);
        check("mdl_m_rdata",  m_rdata,  e_rdata);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_m(input int i, input logic req, input logic cmd,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        m_req[i]              = req;
        m_cmd[i]              = cmd;
        m_addr[i*AW +: AW]    = addr;
        m_wdata[i*DW +: DW]   = wd;
    endtask

    task automatic clear_inputs();
        m_req   = '0;
        m_cmd   = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
    endtask

    // Expected ack order for the round-robin scenario.
    logic [NUM_M-1:0] exp_q[$];

    // ---------------- directed stimulus ----------------
    initial begin
        aresetn = 1'b0;
        clear_inputs();
        m_req = 4'b0001;                  // request held during reset must not be granted
        step();
        step();
        check("rst_busy",  busy, 1'b0);
        check("rst_grant", grant_id, 0);
        check("rst_s_req", s_req, 1'b0);
        check("rst_m_ack", m_ack, 0);
        clear_inputs();
        aresetn = 1'b1;
        step();

        // Single write by master 0.
        set_m(0, 1'b1, 1'b1, 32'h10, 32'hA5);
        step();
        check("wr_grant",  grant_id, 0);
        check("wr_s_addr", s_addr, 32'h10);
        check("wr_s_wdat", s_wdata, 32'hA5);
        check("wr_s_cmd",  s_cmd, 1'b1);
        check("wr_noack",  m_ack, 0);
        step();
        s_ack = 1'b1;
        #1;
        check("wr_m_ack",  m_ack, 4'b0001);
        step();
        clear_inputs();
        #1;
        check("wr_idle",   busy, 1'b0);
        check("wr_noresp", m_resp, 0);
        check("wr_ack_lo", m_ack, 0);

        // Single read by master 2.
        set_m(2, 1'b1, 1'b0, 32'h20, 32'h0);
        step();
        check("rd_grant",  grant_id, 2);
        check("rd_s_addr", s_addr, 32'h20);
        s_ack = 1'b1;
        #1;
        check("rd_m_ack",  m_ack, 4'b0100);
        step();
        clear_inputs();
        s_resp  = 1'b1;
        s_rdata = 32'hDEADBEEF;
        #1;
        check("rd_m_resp", m_resp, 4'b0100);
        check("rd_rdata",  m_rdata, 128'h00000000_DEADBEEF_00000000_00000000);
        step();
        clear_inputs();
        #1;
        check("rd_idle",   busy, 1'b0);
        check("rd_resp_lo", m_resp, 0);

        // Round robin after a fresh reset: all masters writing continuously.
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < NUM_M; i++) set_m(i, 1'b1, 1'b1, AW'(32'h100 + i), DW'(32'h5000 + i));
        s_ack = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            check("rr_m_ack", m_ack, exp_q.pop_front());
            step();
        end
        check("rr_q_empty", exp_q.size(), 0);
        clear_inputs();
        step();

        // Wrap and skip: last grant 2, then masters 0 and 1 request.
        set_m(2, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        check("ws_setup", grant_id, 2);
        s_ack = 1'b1;
        step();
        clear_inputs();
        m_req = 4'b0011;
        m_cmd = 4'b1111;
        step();
        check("ws_first", grant_id, 0);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        step();
        check("ws_second", grant_id, 1);
        s_ack = 1'b1;
        step();
        clear_inputs();

        // Withdrawal: master 3 completes, master 1 granted then drops its request.
        set_m(3, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        s_ack = 1'b1;
        step();
        clear_inputs();
        m_cmd = 4'b1111;
        m_req = 4'b0010;
        step();
        check("wd_grant", grant_id, 1);
        m_req = 4'b0000;
        #1;
        check("wd_noack", m_ack, 0);
        step();
        check("wd_idle", busy, 1'b0);
        m_req = 4'b0110;
        step();
        check("wd_regrant", grant_id, 1);
        s_ack = 1'b1;
        step();
        clear_inputs();

        // Reset while waiting for read data.
        set_m(3, 1'b1, 1'b0, 32'h30, 32'h0);
        step();
        check("rr_rd_grant", grant_id, 3);
        s_ack = 1'b1;
        step();
        clear_inputs();
        step();
        check("rsp_wait_busy", busy, 1'b1);
        aresetn = 1'b0;
        #1;
        check("arst_busy",  busy, 1'b0);
        check("arst_grant", grant_id, 0);
        check("arst_rdata", m_rdata, 0);
        step();
        aresetn = 1'b1;
        s_resp  = 1'b1;
        s_rdata = 32'h12345678;
        #1;
        check("arst_noresp", m_resp, 0);
        check("arst_rdata2", m_rdata, 0);
        step();
        clear_inputs();
        m_req = 4'b1111;
        m_cmd = 4'b1111;
        step();
        check("arst_next", grant_id, 0);
        s_ack = 1'b1;
        step();
        clear_inputs();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
